// File: rtl/qsfp_mgmt_pkg.sv
// Shared definitions for the QSFP management sequencer: state codes,
// default timing constants and the per-state pin decode.
package qsfp_mgmt_pkg;

    localparam int unsigned DEF_REFCLK_RST_CYCLES = 1000;
    localparam int unsigned DEF_MOD_RST_CYCLES    = 1000;
    localparam int unsigned DEF_INIT_CYCLES       = 2000000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES   = 1000;
    localparam int unsigned STATE_W               = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_REFCLK_RST = 3'd1,
        ST_MOD_RST    = 3'd2,
        ST_MOD_INIT   = 3'd3,
        ST_READY      = 3'd4
    } state_t;

    typedef struct packed {
        logic refclk_reset;
        logic mod_reset_n;
        logic lpmode;
        logic modsel_n;
        logic clock_ok;
    } pins_t;

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Module-side pin levels held while in a given state.
    function automatic pins_t state_pins(state_t s);
        pins_t p;
        p = '{refclk_reset: 1'b1, mod_reset_n: 1'b0, lpmode: 1'b1, modsel_n: 1'b1, clock_ok: 1'b0};
        case (s)
            ST_MOD_RST: p.refclk_reset = 1'b0;
            ST_MOD_INIT: begin
                p.refclk_reset = 1'b0;
                p.mod_reset_n  = 1'b1;
                p.lpmode       = 1'b0;
                p.modsel_n     = 1'b0;
            end
            ST_READY: begin
                p.refclk_reset = 1'b0;
                p.mod_reset_n  = 1'b1;
                p.lpmode       = 1'b0;
                p.modsel_n     = 1'b0;
                p.clock_ok     = 1'b1;
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/qsfp_sync_debounce.sv
// Two-flop synchronizer followed by a debouncer: the level output only
// follows the (optionally inverted) input after DEBOUNCE_CYCLES equal samples.
module qsfp_sync_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter bit          INVERT          = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             sample_c;

    assign sample_c = sync2 ^ INVERT;

    // cnt counts consecutive samples that disagree with the current level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            if (sample_c == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sample_c;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/qsfp_mgmt_sequencer.sv
// QSFP module bring-up sequencer: refclk reset, module reset and init wait,
// then READY with interrupt latching and abort accounting.
module qsfp_mgmt_sequencer
    import qsfp_mgmt_pkg::*;
#(
    parameter int unsigned REFCLK_RST_CYCLES = DEF_REFCLK_RST_CYCLES,
    parameter int unsigned MOD_RST_CYCLES    = DEF_MOD_RST_CYCLES,
    parameter int unsigned INIT_CYCLES       = DEF_INIT_CYCLES,
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       restart,
    input  logic [1:0] fs_sel,
    input  logic       sfp_modprs,
    input  logic       sfp_int,
    input  logic       int_clear,
    output logic       sfp_modsel,
    output logic       sfp_reset,
    output logic       sfp_lpmode,
    output logic       sfp_refclk_reset,
    output logic [1:0] sfp_fs,
    output logic       clock_ok,
    output logic [2:0] status,
    output logic       int_pending,
    output logic [7:0] abort_count
);

    localparam int unsigned MAX_CYCLES = max3(REFCLK_RST_CYCLES, MOD_RST_CYCLES, INIT_CYCLES);
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    pins_t            pins_q;
    logic             present;
    logic             int_sync1;
    logic             int_sync2;
    logic             int_prev;
    logic             abort_c;
    logic             int_fall_c;

    qsfp_sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .INVERT         (1'b1)
    ) u_modprs (
        .clock   (clock),
        .reset   (reset),
        .async_in(sfp_modprs),
        .level   (present)
    );

    assign int_fall_c       = int_prev & ~int_sync2;
    assign status           = 3'(state);
    assign sfp_refclk_reset = pins_q.refclk_reset;
    assign sfp_reset        = pins_q.mod_reset_n;
    assign sfp_lpmode       = pins_q.lpmode;
    assign sfp_modsel       = pins_q.modsel_n;
    assign clock_ok         = pins_q.clock_ok;

    // Next state: any abort condition beats timer expiry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        abort_c   = restart || !enable || !present;
        case (state)
            ST_IDLE: begin
                if (enable && present) begin
                    state_nxt = ST_REFCLK_RST;
                    cnt_nxt   = CNT_W'(REFCLK_RST_CYCLES - 1);
                end
            end
            ST_REFCLK_RST, ST_MOD_RST, ST_MOD_INIT: begin
                if (abort_c) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (state == ST_REFCLK_RST) begin
                    state_nxt = ST_MOD_RST;
                    cnt_nxt   = CNT_W'(MOD_RST_CYCLES - 1);
                end else if (state == ST_MOD_RST) begin
                    state_nxt = ST_MOD_INIT;
                    cnt_nxt   = CNT_W'(INIT_CYCLES - 1);
                end else begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (abort_c) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pins_q      <= state_pins(ST_IDLE);
            sfp_fs      <= 2'd0;
            int_sync1   <= 1'b0;
            int_sync2   <= 1'b0;
            int_prev    <= 1'b0;
            int_pending <= 1'b0;
            abort_count <= 8'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pins_q    <= state_pins(state_nxt);
            int_sync1 <= sfp_int;
            int_sync2 <= int_sync1;
            int_prev  <= int_sync2;
            if (state == ST_IDLE && state_nxt == ST_REFCLK_RST) begin
                sfp_fs <= fs_sel;
            end
            if (state == ST_READY && state_nxt == ST_IDLE && abort_count != 8'hFF) begin
                abort_count <= abort_count + 8'd1;
            end
            // Leaving READY clears; a new edge wins over a coincident clear.
            if (state_nxt != ST_READY) begin
                int_pending <= 1'b0;
            end else if (state == ST_READY && int_fall_c) begin
                int_pending <= 1'b1;
            end else if (int_clear) begin
                int_pending <= 1'b0;
            end
        end
    end

endmodule
